// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared Tuse/Tnew encodings, exception vector, MDU latencies and hazard helper.
package pipe_hazard_ctrl_pkg;
  localparam logic [1:0]  TUSE_NONE       = 2'd3;
  localparam logic [31:0] EXC_VECTOR      = 32'h0000_4180;
  localparam int          MULT_CYCLES_DEF = 5;
  localparam int          DIV_CYCLES_DEF  = 10;
  localparam int          CNT_W_DEF       = 4;
  typedef enum logic {IDLE, BUSY} md_state_e;
  // A D-stage source stalls when a younger producer writes it but its result
  // arrives later than the D-stage instruction needs it. Register 0 never stalls;
  // TUSE_NONE can never be exceeded by a 2-bit Tnew, so unused sources never stall.
  function automatic logic reg_hazard(
    input logic [4:0] a,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    return (a != 5'd0) && (((a == e_wa) && (e_tnew > tuse)) || ((a == m_wa) && (m_tnew > tuse)));
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// md_busy_counter: MDU busy counter with start gating and a registered done pulse.
//  clk, reset : clock, synchronous active-high reset
//  i_start    : E-stage mult/div start
//  i_op       : 0 = mult family, 1 = div family
//  i_req      : exception flush; a start during it is discarded
//  o_busy     : counter non-zero
//  o_done     : one-cycle pulse the cycle the counter reaches 0
module md_busy_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_op,
  input  logic i_req,
  output logic o_busy,
  output logic o_done
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done_nxt;
  md_state_e        w_state;
  // A busy counter keeps counting through Req and ignores stray starts, so an
  // in-flight operation always completes.
  always_comb begin
    w_state    = (r_cnt != '0) ? BUSY : IDLE;
    w_cnt_nxt  = (w_state == BUSY) ? r_cnt - CNT_W'(1) :
                 (i_start && !i_req) ? (i_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) : r_cnt;
    w_done_nxt = (w_state == BUSY) && (r_cnt == CNT_W'(1));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end
  assign o_busy = (r_cnt != '0);
  assign o_done = r_done;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/exception sequencer beside the D stage.
//  Inputs : D-stage source addresses and Tuse, E/M write addresses and Tnew,
//           MDU start/op, M-stage exception code, masked interrupt request.
//  Outputs: stall (PC/D hold), E_clr (E bubble), Req (global flush to 0x4180),
//           md_busy / md_done from the MDU busy counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs_addr,
  input  logic [4:0] D_rt_addr,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic       D_is_md,
  input  logic [4:0] E_wa,
  input  logic [1:0] E_Tnew,
  input  logic [4:0] M_wa,
  input  logic [1:0] M_Tnew,
  input  logic       E_md_start,
  input  logic       E_md_op,
  input  logic [4:0] M_ExcCode,
  input  logic       IntReq,
  output logic       stall,
  output logic       E_clr,
  output logic       Req,
  output logic       md_busy,
  output logic       md_done
);
  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_req;
  logic w_busy;
  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_start(E_md_start),
    .i_op   (E_md_op),
    .i_req  (w_req),
    .o_busy (w_busy),
    .o_done (md_done)
  );
  // Req wins over every stall source: a flushing cycle must not also hold PC.
  always_comb begin
    w_req      = (M_ExcCode != 5'd0) || IntReq;
    w_stall_rs = reg_hazard(D_rs_addr, D_Tuse_rs, E_wa, E_Tnew, M_wa, M_Tnew);
    w_stall_rt = reg_hazard(D_rt_addr, D_Tuse_rt, E_wa, E_Tnew, M_wa, M_Tnew);
    w_stall_md = D_is_md && (w_busy || E_md_start);
    stall      = (w_stall_rs || w_stall_rt || w_stall_md) && !w_req;
    E_clr      = stall;
    Req        = w_req;
    md_busy    = w_busy;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs_addr, D_rt_addr, E_wa, M_wa, M_ExcCode;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic       D_is_md, E_md_start, E_md_op, IntReq;
  logic       stall, E_clr, Req, md_busy, md_done;
  typedef struct {
    string nm;
    logic  st;
    logic  rq;
    logic  bz;
    logic  dn;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  pipe_hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .D_rs_addr (D_rs_addr),
    .D_rt_addr (D_rt_addr),
    .D_Tuse_rs (D_Tuse_rs),
    .D_Tuse_rt (D_Tuse_rt),
    .D_is_md   (D_is_md),
    .E_wa      (E_wa),
    .E_Tnew    (E_Tnew),
    .M_wa      (M_wa),
    .M_Tnew    (M_Tnew),
    .E_md_start(E_md_start),
    .E_md_op   (E_md_op),
    .M_ExcCode (M_ExcCode),
    .IntReq    (IntReq),
    .stall     (stall),
    .E_clr     (E_clr),
    .Req       (Req),
    .md_busy   (md_busy),
    .md_done   (md_done)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string nm, input string f, input logic a, input logic e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s.%s got=%b exp=%b", nm, f, a, e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.nm, "stall", stall, e.st);
        cmp(e.nm, "E_clr", E_clr, e.st);
        cmp(e.nm, "Req", Req, e.rq);
        cmp(e.nm, "md_busy", md_busy, e.bz);
        cmp(e.nm, "md_done", md_done, e.dn);
      end
    end
  end
  task automatic idle();
    D_rs_addr = 0; D_rt_addr = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_is_md = 0;
    E_wa = 0; E_Tnew = 0; M_wa = 0; M_Tnew = 0;
    E_md_start = 0; E_md_op = 0; M_ExcCode = 0; IntReq = 0;
  endtask
  task automatic cyc(input string nm, input logic st, input logic rq, input logic bz, input logic dn);
    exp_t e;
    e.nm = nm; e.st = st; e.rq = rq; e.bz = bz; e.dn = dn;
    q.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", 0, 0, 0, 0);
    reset = 1'b0;
    D_rs_addr = 5; D_Tuse_rs = 0; E_wa = 5; E_Tnew = 1;
    cyc("rs_E_hazard", 1, 0, 0, 0);
    D_rs_addr = 5; D_Tuse_rs = 0; M_wa = 5; M_Tnew = 0;
    cyc("rs_M_ready", 0, 0, 0, 0);
    D_rt_addr = 7; D_Tuse_rt = 1; M_wa = 7; M_Tnew = 2;
    cyc("rt_M_hazard", 1, 0, 0, 0);
    D_rt_addr = 7; D_Tuse_rt = 1; E_wa = 7; E_Tnew = 1;
    cyc("rt_tnew_eq_tuse", 0, 0, 0, 0);
    D_rt_addr = 0; D_Tuse_rt = 0; E_wa = 0; E_Tnew = 2;
    cyc("rt_zero_reg", 0, 0, 0, 0);
    D_rs_addr = 9; D_Tuse_rs = 3; E_wa = 9; E_Tnew = 2;
    cyc("rs_unused", 0, 0, 0, 0);
    D_rs_addr = 5; D_Tuse_rs = 0; E_wa = 5; E_Tnew = 2; IntReq = 1;
    cyc("req_beats_stall", 0, 1, 0, 0);
    D_is_md = 1; E_md_start = 1; E_md_op = 1;
    cyc("div_t0", 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      D_is_md = 1;
      cyc($sformatf("div_t%0d", i), 1, 0, 1, 0);
    end
    D_is_md = 1;
    cyc("div_t11", 0, 0, 0, 1);
    cyc("div_t12", 0, 0, 0, 0);
    E_md_start = 1; E_md_op = 0;
    cyc("mul_t0", 0, 0, 0, 0);
    cyc("mul_t1", 0, 0, 1, 0);
    M_ExcCode = 4; D_is_md = 1;
    cyc("mul_t2_exc", 0, 1, 1, 0);
    E_md_start = 1; E_md_op = 1;
    cyc("mul_t3_stray", 0, 0, 1, 0);
    cyc("mul_t4", 0, 0, 1, 0);
    cyc("mul_t5", 0, 0, 1, 0);
    cyc("mul_t6", 0, 0, 0, 1);
    cyc("mul_t7", 0, 0, 0, 0);
    E_md_start = 1; E_md_op = 1; IntReq = 1;
    cyc("start_in_req", 0, 1, 0, 0);
    cyc("start_in_req_n1", 0, 0, 0, 0);
    cyc("start_in_req_n2", 0, 0, 0, 0);
    E_md_start = 1; E_md_op = 1;
    cyc("rst_t0", 0, 0, 0, 0);
    cyc("rst_t1", 0, 0, 1, 0);
    cyc("rst_t2", 0, 0, 1, 0);
    reset = 1'b1;
    cyc("rst_t3", 0, 0, 1, 0);
    reset = 1'b0;
    for (int i = 4; i <= 16; i++) cyc($sformatf("rst_t%0d", i), 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d exp=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
